// File: rtl/diff_pkg_80.sv
// Shared types and helpers for the first-difference stage.
//   diff_state_t : PRIME (no previous sample held) / RUN (previous sample held)
//   DIFF_DATA_W  : default signed sample width
//   sat_to_w     : clamp a signed value to the signed range of a given width
//                  (used only when DIFF_SAT_EN is defined)
package diff_pkg_80;

    localparam int unsigned DIFF_DATA_W = 4;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } diff_state_t;

    // Clamp value into [-2^(w-1), 2^(w-1)-1].
    function automatic logic signed [31:0] sat_to_w(input logic signed [31:0] value,
                                                    input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = $signed(32'(32'd1 << (w - 32'd1))) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/diff_hold_reg_80.sv
// Width-parameterised holding register with async reset, sync clear and load enable.
//   clk_80, rst_n_80 : clock / async active-low reset
//   clr              : synchronous clear to zero (wins over en)
//   en               : load d into q
//   d, q             : data in / held value
module diff_hold_reg_80 #(
    parameter int unsigned W = 4
) (
    input  logic         clk_80,
    input  logic         rst_n_80,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_80 or negedge rst_n_80) begin
        if (!rst_n_80) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/diff_stage_80.sv
// First-difference stage: y[n] = x[n] - x[n-1], single-entry valid/ready pipeline.
// Optional build macro DIFF_SAT_EN clamps y to the DATA_W signed range and adds out_sat_80.
//   clk_80, rst_n_80           : clock / async active-low reset
//   clr_80                     : sync clear back to PRIME, drops pending output
//   in_valid_80/in_ready_80    : upstream handshake (in_ready_80 is combinational)
//   in_data_80                 : signed sample x[n]
//   out_valid_80/out_ready_80  : downstream handshake
//   out_data_80                : signed difference y[n]
//   primed_80                  : high while a previous sample is held
//   out_sat_80 (DIFF_SAT_EN)   : current out_data_80 was clamped
module diff_stage_80
    import diff_pkg_80::*;
#(
    parameter int unsigned DATA_W = DIFF_DATA_W,
    parameter int unsigned OUT_W  = DATA_W + 1
) (
    input  logic              clk_80,
    input  logic              rst_n_80,
    input  logic              clr_80,
    input  logic              in_valid_80,
    output logic              in_ready_80,
    input  logic [DATA_W-1:0] in_data_80,
    output logic              out_valid_80,
    input  logic              out_ready_80,
    output logic [OUT_W-1:0]  out_data_80,
    output logic              primed_80
`ifdef DIFF_SAT_EN
    ,
    output logic              out_sat_80
`endif
);

    diff_state_t              state_q;
    diff_state_t              state_d;
    logic                     valid_d;
    logic [OUT_W-1:0]         data_d;
    logic                     in_fire;
    logic                     out_fire;
    logic [DATA_W-1:0]        prev_q;
    logic signed [OUT_W-1:0]  in_ext;
    logic signed [OUT_W-1:0]  prev_ext;
    logic signed [OUT_W-1:0]  diff_full;
    logic [OUT_W-1:0]         diff_res;

    // Clear blocks acceptance so a sample presented with clr_80 is never consumed.
    assign in_ready_80 = !clr_80 && (!out_valid_80 || out_ready_80);
    assign in_fire     = in_valid_80 && in_ready_80;
    assign out_fire    = out_valid_80 && out_ready_80;

    // Previous accepted sample.
    diff_hold_reg_80 #(
        .W (DATA_W)
    ) u_prev (
        .clk_80   (clk_80),
        .rst_n_80 (rst_n_80),
        .clr      (clr_80),
        .en       (in_fire),
        .d        (in_data_80),
        .q        (prev_q)
    );

    // Full-precision difference; OUT_W = DATA_W+1 cannot overflow.
    assign in_ext    = OUT_W'($signed(in_data_80));
    assign prev_ext  = OUT_W'($signed(prev_q));
    assign diff_full = in_ext - prev_ext;

`ifdef DIFF_SAT_EN
    logic signed [31:0] diff_int;
    logic signed [31:0] clamp_int;
    logic               diff_sat;
    logic               sat_d;

    assign diff_int  = 32'(diff_full);
    assign clamp_int = sat_to_w(diff_int, DATA_W);
    assign diff_res  = OUT_W'(clamp_int);
    assign diff_sat  = (clamp_int != diff_int);
`else
    assign diff_res  = diff_full;
`endif

    // Next-state and output-register values.
    always_comb begin
        state_d = state_q;
        valid_d = out_valid_80;
        data_d  = out_data_80;
`ifdef DIFF_SAT_EN
        sat_d   = out_sat_80;
`endif
        if (clr_80) begin
            state_d = PRIME;
            valid_d = 1'b0;
`ifdef DIFF_SAT_EN
            sat_d   = 1'b0;
`endif
        end else begin
            if (out_fire) begin
                valid_d = 1'b0;
            end
            if (in_fire) begin
                case (state_q)
                    PRIME: begin
                        state_d = RUN;
                    end
                    RUN: begin
                        valid_d = 1'b1;
                        data_d  = diff_res;
`ifdef DIFF_SAT_EN
                        sat_d   = diff_sat;
`endif
                    end
                    default: begin
                        state_d = PRIME;
                    end
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_80 or negedge rst_n_80) begin
        if (!rst_n_80) begin
            state_q      <= PRIME;
            out_valid_80 <= 1'b0;
            out_data_80  <= '0;
            primed_80    <= 1'b0;
`ifdef DIFF_SAT_EN
            out_sat_80   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_80 <= valid_d;
            out_data_80  <= data_d;
            primed_80    <= (state_d == RUN);
`ifdef DIFF_SAT_EN
            out_sat_80   <= sat_d;
`endif
        end
    end

endmodule
